// File: rtl/mac8_seq_mac_pkg.sv
// Shared definitions for the sequential 8x8 MAC: FSM encoding, defaults and the
// per-step nibble selection / shift table used by the multiply sequencer.
package mac8_pkg;

  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned MUL_STEPS = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StAcc  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Operands captured at the accept edge.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
  } op_t;

  // Step order: lo*lo, lo*hi, hi*lo, hi*hi. Bit 1 picks the a nibble, bit 0 the b nibble.
  function automatic logic step_a_hi(input logic [1:0] step);
    return step[1];
  endfunction

  function automatic logic step_b_hi(input logic [1:0] step);
    return step[0];
  endfunction

  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mac8_seq_mac_if.sv
// Operand/result handshake bundle between the I/O capture logic and the MAC.
interface mac8_seq_mac_if #(
  parameter int unsigned ACC_W = 20
);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             acc_clr;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output acc_clr,
    input  in_ready,
    input  out_valid,
    input  acc,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  acc_clr,
    output in_ready,
    output out_valid,
    output acc,
    output ovf
  );

endinterface

// File: rtl/mac8_seq_mac_vedic_4bit_multiplier.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from
// four 2x2 blocks.
module vedic_4bit_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, t2, c1;
    logic [3:0] r;
    t0   = x[1] & y[0];
    t1   = x[0] & y[1];
    t2   = x[1] & y[1];
    c1   = t0 & t1;
    r[0] = x[0] & y[0];
    r[1] = t0 ^ t1;
    r[2] = t2 ^ c1;
    r[3] = t2 & c1;
    return r;
  endfunction

  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;

  always_comb begin
    q_ll = vedic_2x2(a[1:0], b[1:0]);
    q_hl = vedic_2x2(a[3:2], b[1:0]);
    q_lh = vedic_2x2(a[1:0], b[3:2]);
    q_hh = vedic_2x2(a[3:2], b[3:2]);
    p    = {4'b0, q_ll} + {2'b0, q_hl, 2'b0} + {2'b0, q_lh, 2'b0} + {q_hh, 4'b0};
  end

endmodule

// File: rtl/mac8_seq_mac.sv
// Sequential 8x8 unsigned MAC: one 4x4 core is time-shared over four cycles to
// form a 16-bit product, which is then added into a wrapping accumulator.
module mac8_seq_mac
  import mac8_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  mac8_seq_mac_if.slave   bus
);

  localparam int unsigned SUM_W = ACC_W + 1;

  if (ACC_W < 16) begin : g_acc_w_check
    $error("ACC_W must be at least 16");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       step_q, step_d;
  op_t              op_q, op_d;
  logic [15:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [7:0]       partial;
  logic [15:0]      prod_add;
  logic [SUM_W-1:0] acc_sum;

  // Nibble mux is driven from latched operands only, so bus changes mid-MUL are ignored.
  always_comb begin
    a_nib    = step_a_hi(step_q) ? op_q.a[7:4] : op_q.a[3:0];
    b_nib    = step_b_hi(step_q) ? op_q.b[7:4] : op_q.b[3:0];
    prod_add = prod_q + ({8'b0, partial} << step_shift(step_q));
    acc_sum  = SUM_W'(acc_q) + SUM_W'(prod_q);
  end

  vedic_4bit_multiplier u_core (
    .a (a_nib),
    .b (b_nib),
    .p (partial)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d.a   = bus.a;
          op_d.b   = bus.b;
          op_d.clr = bus.acc_clr;
          prod_d   = '0;
          step_d   = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        prod_d = prod_add;
        step_d = step_q + 2'd1;
        if (step_q == 2'(MUL_STEPS - 1)) begin
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (op_q.clr) begin
          acc_d = ACC_W'(prod_q);
          ovf_d = 1'b0;
        end else begin
          acc_d = acc_sum[ACC_W-1:0];
          ovf_d = ovf_q | acc_sum[ACC_W];
        end
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      op_q    <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.acc       = acc_q;
    bus.ovf       = ovf_q;
  end

endmodule

// File: tb/tb_mac8_seq_mac.sv
// Self-checking bench for mac8_seq_mac: transaction-level model plus directed
// vectors with hand-computed results.
module tb_mac8_seq_mac;

  logic clk = 1'b0;
  logic rst_n;

  mac8_seq_mac_if #(.ACC_W(20)) bus ();

  mac8_seq_mac #(.ACC_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: an accepted pair completes 6 cycles later; the accumulator
  // updates at the 5th edge after accept and the unit is free again after the 6th.
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [19:0] m_acc  = '0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_prod = '0;
  logic        m_clr  = 1'b0;
  logic [20:0] m_sum;

  assign m_sum = {1'b0, m_acc} + {5'b0, m_prod};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_acc  <= '0;
      m_ovf  <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        if (m_clr) begin
          m_acc <= 20'(m_prod);
          m_ovf <= 1'b0;
        end else begin
          m_acc <= m_sum[19:0];
          m_ovf <= m_ovf | m_sum[20];
        end
      end
      if (m_left == 1) m_busy <= 1'b0;
    end else if (bus.in_valid) begin
      m_busy <= 1'b1;
      m_left <= 6;
      m_prod <= 16'(bus.a) * 16'(bus.b);
      m_clr  <= bus.acc_clr;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.in_ready, !m_busy);
      check("out_valid", bus.out_valid, (m_busy && m_left == 1));
      check("acc", bus.acc, m_acc);
      check("ovf", bus.ovf, m_ovf);
      if (bus.out_valid) ov_count++;
    end
  end

  // Starts at a negedge, returns at the negedge of the out_valid cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                       input logic [19:0] exp_acc, input logic exp_ovf, input string name);
    int lat;
    lat = 0;
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.acc_clr  = clr;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = b ^ 8'h5A;
    bus.acc_clr  = ~clr;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, 6);
    check({name, "_acc"}, bus.acc, exp_acc);
    check({name, "_ovf"}, bus.ovf, exp_ovf);
  endtask

  initial begin
    int ov_before;
    logic any_ov;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.acc_clr  = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acc", bus.acc, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'hFF, 8'hFF, 1'b1, 20'h0FE01, 1'b0, "ff_x_ff");
    do_op(8'h12, 8'h34, 1'b1, 20'h003A8, 1'b0, "x12_x34");
    do_op(8'h01, 8'h01, 1'b0, 20'h003A9, 1'b0, "plus_one");

    do_op(8'hFF, 8'hFF, 1'b1, 20'h0FE01, 1'b0, "ovf_first");
    for (int k = 2; k <= 16; k++) begin
      do_op(8'hFF, 8'hFF, 1'b0, 20'(k * 32'hFE01), 1'b0, "ovf_run");
    end
    check("ovf_16_acc", bus.acc, 32'hFE010);
    do_op(8'hFF, 8'hFF, 1'b0, 20'h0DE11, 1'b1, "ovf_17");
    do_op(8'h02, 8'h03, 1'b1, 20'h00006, 1'b0, "ovf_clear");

    // in_valid held high with operands changing every cycle.
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    ov_before    = ov_count;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.acc_clr  = 1'b1;
    bus.in_valid = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      bus.a       = 8'($urandom);
      bus.b       = 8'($urandom);
      bus.acc_clr = 1'($urandom);
    end
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("backpressure_results", ov_count - ov_before, 3);

    do_op(8'h10, 8'h10, 1'b1, 20'h00100, 1'b0, "pre_reset");
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    bus.a        = 8'h01;
    bus.b        = 8'h01;
    bus.acc_clr  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midmul_rst_acc", bus.acc, 0);
    check("midmul_rst_ovf", bus.ovf, 0);
    check("midmul_rst_in_ready", bus.in_ready, 1);
    any_ov = bus.out_valid;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      any_ov = any_ov | bus.out_valid;
    end
    check("midmul_no_out_valid", any_ov, 0);
    do_op(8'h03, 8'h05, 1'b0, 20'h0000F, 1'b0, "after_reset");

    do_op(8'h00, 8'hFF, 1'b1, 20'h00000, 1'b0, "zero_a");
    do_op(8'hF0, 8'h0F, 1'b0, 20'h00E10, 1'b0, "cross_only");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
